bg_scroll_gen: RTL and testbench
================================

# bg_scroll_gen

Video timing and scroll-coordinate generator directly upstream of the background tile layer. It runs the horizontal and vertical pixel counters and holds the CPU-written background scroll registers. Every pixel it produces the scrolled coordinates (HPIXSCRL, VPIXSCRL) plus raw VPIX and blanking for the background fetch/shift pipeline. Scroll values are double-buffered so that CPU writes take effect only at vertical-blank start, which prevents mid-frame tearing.

## Interface
- H_TOTAL, 384: pixels per line; hcnt range 0..H_TOTAL-1.
- V_TOTAL, 264: lines per frame; vcnt range 0..V_TOTAL-1.
- H_ACTIVE, 256: hcnt < H_ACTIVE is visible; HBLANK otherwise.
- V_ACTIVE, 240: vcnt < V_ACTIVE is visible; VBLANK otherwise. Scroll latch occurs at vcnt==V_ACTIVE.
- master_clk  in  1  sole clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- pixel_ce  in  1  pixel advance enable, one master_clk cycle wide.
- SCREEN_FLIP  in  1  1 = inverted screen.
- SCROLL_CS  in  1  active-low chip select for the scroll register window.
- Z80_WR  in  1  active-low CPU write strobe.
- CPU_ADDR  in  2  register select, CPU_ADDR[1:0].
- CPU_DIN  in  8  CPU write data.
- HPIXSCRL  out  9  scrolled horizontal coordinate.
- VPIXSCRL  out  8  scrolled vertical coordinate.
- VPIX  out  8  unscrolled vertical coordinate, flip-adjusted.
- HBLANK  out  1  horizontal blank.
- VBLANK  out  1  vertical blank.
- FRAME_START  out  1  one-master_clk pulse when the latch fires.

## Operation
- Counters:
  - On each pixel_ce, hcnt increments.
  - At H_TOTAL-1, hcnt wraps to 0 and vcnt increments.
  - At V_TOTAL-1 with hcnt wrapping, vcnt wraps to 0.
  - With no pixel_ce, the counters hold.
- CPU write detection:
  - wr_act = !SCROLL_CS & !Z80_WR.
  - A write commits on the first master_clk where wr_act is 1 and was 0 on the previous cycle.
  - A strobe held for many cycles writes exactly once.
- Pending registers:
  - CPU_ADDR 0 → pend_x[7:0] = CPU_DIN.
  - CPU_ADDR 1 → pend_x[8] = CPU_DIN[0].
  - CPU_ADDR 2 → pend_y = CPU_DIN.
  - CPU_ADDR 3 → ignored.
- Latch:
  - Fires on the pixel_ce that moves the counters to (hcnt=0, vcnt=V_ACTIVE).
  - It copies pend_x → act_x and pend_y → act_y, and pulses FRAME_START.
- Write coinciding with the latch: the latch copies the pre-write pending value; the new value stays pending until the next frame.
- Flip-adjusted counters:
  - heff = SCREEN_FLIP ? ~hcnt[8:0] : hcnt[8:0].
  - veff = SCREEN_FLIP ? ~vcnt[7:0] : vcnt[7:0].
- Arithmetic:
  - HPIXSCRL = (heff + act_x) mod 512.
  - VPIXSCRL = (veff + act_y) mod 256.
  - VPIX = veff.
  - No saturation; carries are discarded.
- Blanking:
  - HBLANK = (hcnt >= H_ACTIVE).
  - VBLANK = (vcnt >= V_ACTIVE).
- SCREEN_FLIP is sampled combinationally into the output register; a change mid-frame takes effect on the next output update.

## Timing
- Reset state:
  - hcnt, vcnt, pend_x, pend_y, act_x, act_y all 0.
  - FRAME_START 0.
  - On the cycle after reset deasserts: HPIXSCRL=0, VPIXSCRL=0, VPIX=0, HBLANK=0, VBLANK=0 when SCREEN_FLIP=0.
  - With SCREEN_FLIP=1: HPIXSCRL=0x1FF, VPIXSCRL=0xFF, VPIX=0xFF.
- Reset mid-frame discards any pending write and restarts at (0,0).
- Counters and act_x/act_y update on the master_clk edge where pixel_ce=1.
- All outputs are registered one master_clk after the counter/act update.
  - Total latency from a pixel_ce to the matching output is 1 master_clk.
  - Outputs are then stable until the next pixel_ce plus 1.
- FRAME_START is high exactly in the output cycle corresponding to (0, V_ACTIVE).
- A CPU write committed at cycle N is visible in pend_* at N+1. It is never visible on the outputs before the next latch.

## Test plan
- Reset, SCREEN_FLIP=0 → all outputs 0, FRAME_START 0. Run 384×264 pixel_ce → hcnt/vcnt wrap to (0,0), and exactly one FRAME_START is seen.
- At vcnt=100, write addr0=0x34, addr1=0x01, addr2=0x10 → HPIXSCRL/VPIXSCRL unchanged until vcnt=240. Afterwards, at hcnt=0, vcnt=0: HPIXSCRL=0x134, VPIXSCRL=0x10.
- act_x=0x1F0 at hcnt=0x20 → HPIXSCRL=0x010 (9-bit wrap). act_y=0xF8 at vcnt=0x10 → VPIXSCRL=0x08.
- Write addr2=0x55 on the same master_clk as the latch pixel_ce → act_y keeps its old value this frame and becomes 0x55 at the following frame's latch.
- Hold SCROLL_CS=0, Z80_WR=0 for 20 cycles with CPU_DIN changing each cycle → pend register holds only the data from the first cycle.
- SCREEN_FLIP=1, act=0, hcnt=5, vcnt=3 → HPIXSCRL=0x1FA, VPIXSCRL=0xFC, VPIX=0xFC. HBLANK=1 at hcnt=256, VBLANK=1 at vcnt=240.

Source files
------------

// File: rtl/bg_scroll_gen.sv
// Pixel/line counters and double-buffered background scroll, producing scrolled coordinates per pixel.
// Outputs registered 1 master_clk after each counter update; no backpressure (advances on pixel_ce).
module bg_scroll_gen #(
  parameter int H_TOTAL  = 384,
  parameter int V_TOTAL  = 264,
  parameter int H_ACTIVE = 256,
  parameter int V_ACTIVE = 240
) (
  input  logic       master_clk,
  input  logic       reset,
  input  logic       pixel_ce,
  input  logic       SCREEN_FLIP,
  input  logic       SCROLL_CS,
  input  logic       Z80_WR,
  input  logic [1:0] CPU_ADDR,
  input  logic [7:0] CPU_DIN,
  output logic [8:0] HPIXSCRL,
  output logic [7:0] VPIXSCRL,
  output logic [7:0] VPIX,
  output logic       HBLANK,
  output logic       VBLANK,
  output logic       FRAME_START
);

  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
  localparam logic [8:0] H_ACT  = 9'(H_ACTIVE);
  localparam logic [8:0] V_ACT  = 9'(V_ACTIVE);

  logic [8:0] hcnt, vcnt, h_nxt, v_nxt;
  logic [8:0] pend_x, act_x, heff;
  logic [7:0] pend_y, act_y, veff;
  logic       wr_act, wr_act_d, wr_commit;
  logic       latch_fire, latched;

  always_comb begin
    h_nxt = hcnt + 9'd1;
    v_nxt = vcnt;
    if (hcnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = (vcnt == V_LAST) ? 9'd0 : vcnt + 9'd1;
    end
  end

  assign latch_fire = pixel_ce && (h_nxt == 9'd0) && (v_nxt == V_ACT);
  assign wr_act     = !SCROLL_CS && !Z80_WR;
  assign wr_commit  = wr_act && !wr_act_d;
  assign heff       = SCREEN_FLIP ? ~hcnt : hcnt;
  assign veff       = SCREEN_FLIP ? ~vcnt[7:0] : vcnt[7:0];

  always_ff @(posedge master_clk) begin
    if (reset) begin
      hcnt     <= '0;
      vcnt     <= '0;
      pend_x   <= '0;
      pend_y   <= '0;
      act_x    <= '0;
      act_y    <= '0;
      wr_act_d <= 1'b0;
      latched  <= 1'b0;
    end else begin
      wr_act_d <= wr_act;
      latched  <= latch_fire;
      if (pixel_ce) begin
        hcnt <= h_nxt;
        vcnt <= v_nxt;
      end
      // act_* takes the pre-write pending value when a write lands on the latch edge
      if (latch_fire) begin
        act_x <= pend_x;
        act_y <= pend_y;
      end
      if (wr_commit) begin
        case (CPU_ADDR)
          2'd0:    pend_x[7:0] <= CPU_DIN;
          2'd1:    pend_x[8]   <= CPU_DIN[0];
          2'd2:    pend_y      <= CPU_DIN;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge master_clk) begin
    if (reset) begin
      HPIXSCRL    <= {9{SCREEN_FLIP}};
      VPIXSCRL    <= {8{SCREEN_FLIP}};
      VPIX        <= {8{SCREEN_FLIP}};
      HBLANK      <= 1'b0;
      VBLANK      <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      HPIXSCRL    <= heff + act_x;
      VPIXSCRL    <= veff + act_y;
      VPIX        <= veff;
      HBLANK      <= (hcnt >= H_ACT);
      VBLANK      <= (vcnt >= V_ACT);
      FRAME_START <= latched;
    end
  end

endmodule

// File: tb/tb_bg_scroll_gen.sv
// Bench for bg_scroll_gen: directed steps plus random traffic against a position-based frame model.
module tb_bg_scroll_gen;

  localparam int HT = 384;
  localparam int HA = 256;
  localparam int VT = 20;
  localparam int VA = 17;
  localparam int FRAME = HT * VT;

  logic       master_clk = 1'b0;
  logic       reset = 1'b1;
  logic       pixel_ce = 1'b0;
  logic       SCREEN_FLIP = 1'b0;
  logic       SCROLL_CS = 1'b1;
  logic       Z80_WR = 1'b1;
  logic [1:0] CPU_ADDR = 2'd0;
  logic [7:0] CPU_DIN = 8'd0;
  logic [8:0] HPIXSCRL;
  logic [7:0] VPIXSCRL, VPIX;
  logic       HBLANK, VBLANK, FRAME_START;

  int checks = 0;
  int errors = 0;
  int fs_seen = 0;

  // model: linear pixel position within the frame plus register contents
  int m_p, m_px, m_py, m_ax, m_ay;
  bit m_prev, m_fired;

  bg_scroll_gen #(.H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
    .master_clk(master_clk), .reset(reset), .pixel_ce(pixel_ce), .SCREEN_FLIP(SCREEN_FLIP),
    .SCROLL_CS(SCROLL_CS), .Z80_WR(Z80_WR), .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN),
    .HPIXSCRL(HPIXSCRL), .VPIXSCRL(VPIXSCRL), .VPIX(VPIX), .HBLANK(HBLANK),
    .VBLANK(VBLANK), .FRAME_START(FRAME_START)
  );

  always #5 master_clk = ~master_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic ce, input logic cs, input logic wr,
                       input logic [1:0] a, input logic [7:0] d);
    int h, v, he, ve, e_hp, e_vp, e_vx, old_px, old_py;
    bit e_hb, e_vb, e_fs, wr_now;
    pixel_ce = ce; SCROLL_CS = cs; Z80_WR = wr; CPU_ADDR = a; CPU_DIN = d;
    if (reset) begin
      e_hp = SCREEN_FLIP ? 511 : 0;
      e_vp = SCREEN_FLIP ? 255 : 0;
      e_vx = e_vp; e_hb = 0; e_vb = 0; e_fs = 0;
      m_p = 0; m_px = 0; m_py = 0; m_ax = 0; m_ay = 0; m_prev = 0; m_fired = 0;
    end else begin
      h = m_p % HT;
      v = m_p / HT;
      he = SCREEN_FLIP ? (~h) & 511 : h;
      ve = SCREEN_FLIP ? (~v) & 255 : v & 255;
      e_hp = (he + m_ax) % 512;
      e_vp = (ve + m_ay) % 256;
      e_vx = ve;
      e_hb = (h >= HA);
      e_vb = (v >= VA);
      e_fs = m_fired;
      old_px = m_px; old_py = m_py;
      wr_now = !cs && !wr;
      if (wr_now && !m_prev) begin
        if (a == 2'd0) m_px = (m_px & 256) | d;
        else if (a == 2'd1) m_px = (m_px & 255) | (d[0] ? 256 : 0);
        else if (a == 2'd2) m_py = d;
      end
      m_prev = wr_now;
      m_fired = 0;
      if (ce) begin
        m_p = (m_p + 1) % FRAME;
        if (m_p == VA * HT) begin
          m_fired = 1; m_ax = old_px; m_ay = old_py;
        end
      end
    end
    @(posedge master_clk);
    @(negedge master_clk);
    chk("HPIXSCRL", 32'(HPIXSCRL), 32'(e_hp));
    chk("VPIXSCRL", 32'(VPIXSCRL), 32'(e_vp));
    chk("VPIX", 32'(VPIX), 32'(e_vx));
    chk("HBLANK", 32'(HBLANK), 32'(e_hb));
    chk("VBLANK", 32'(VBLANK), 32'(e_vb));
    chk("FRAME_START", 32'(FRAME_START), 32'(e_fs));
    if (FRAME_START === 1'b1) fs_seen++;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b1, 1'b1, 2'd0, 8'd0);
  endtask

  task automatic run_to(input int tp);
    for (int i = 0; i < FRAME && m_p != tp; i++) cycle(1'b1, 1'b1, 1'b1, 2'd0, 8'd0);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    cycle(1'b0, 1'b0, 1'b0, a, d);
    cycle(1'b0, 1'b1, 1'b1, a, d);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(); idle();
    reset = 1'b0;
  endtask

  initial begin
    int strobe_left;
    logic [1:0] ra;
    strobe_left = 0;
    ra = 2'd0;

    // reset state and one full frame
    do_reset();
    idle();
    chk("rst_hpix", 32'(HPIXSCRL), 32'h0);
    chk("rst_vpix", 32'(VPIX), 32'h0);
    chk("rst_fs", 32'(FRAME_START), 32'h0);
    fs_seen = 0;
    for (int i = 0; i < FRAME; i++) cycle(1'b1, 1'b1, 1'b1, 2'd0, 8'd0);
    idle();
    chk("frame_fs_count", 32'(fs_seen), 32'd1);
    chk("wrap_hpix", 32'(HPIXSCRL), 32'h0);
    chk("wrap_vpix", 32'(VPIX), 32'h0);

    // mid-frame writes take effect only after the latch
    run_to(10 * HT + 7);
    wr_reg(2'd0, 8'h34); wr_reg(2'd1, 8'h01); wr_reg(2'd2, 8'h10);
    run_to(VA * HT - 1); idle();
    chk("pre_latch_vscrl", 32'(VPIXSCRL), 32'(VA - 1));
    run_to(0); idle();
    chk("frame_hscrl", 32'(HPIXSCRL), 32'h134);
    chk("frame_vscrl", 32'(VPIXSCRL), 32'h10);

    // 9-bit and 8-bit wrap
    wr_reg(2'd0, 8'hF0); wr_reg(2'd1, 8'h01); wr_reg(2'd2, 8'hF8);
    run_to(VA * HT); run_to(16 * HT + 32'h20); idle();
    chk("wrap9_hscrl", 32'(HPIXSCRL), 32'h010);
    chk("wrap8_vscrl", 32'(VPIXSCRL), 32'h08);

    // write on the latch edge stays pending one more frame
    run_to(VA * HT - 1);
    cycle(1'b1, 1'b0, 1'b0, 2'd2, 8'h55);
    idle();
    chk("coinc_old_vscrl", 32'(VPIXSCRL), 32'((VA + 8'hF8) & 8'hFF));
    run_to(0); run_to(VA * HT); idle();
    chk("coinc_new_vscrl", 32'(VPIXSCRL), 32'((VA + 8'h55) & 8'hFF));

    // held strobe writes only the first cycle's data
    cycle(1'b0, 1'b0, 1'b0, 2'd2, 8'hA5);
    for (int i = 0; i < 19; i++) cycle(1'b1, 1'b0, 1'b0, 2'd2, 8'($urandom));
    idle();
    run_to(VA * HT - 1); run_to(VA * HT); idle();
    chk("hold_vscrl", 32'(VPIXSCRL), 32'((VA + 8'hA5) & 8'hFF));

    // random traffic
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 1500) == 0) SCREEN_FLIP = ~SCREEN_FLIP;
      if (strobe_left > 0) begin
        strobe_left--;
        cycle(1'($urandom_range(0, 7) != 0), 1'b0, 1'b0, ra, 8'($urandom));
      end else begin
        if ($urandom_range(0, 30) == 0) begin
          strobe_left = $urandom_range(1, 20);
          ra = 2'($urandom);
        end
        cycle(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom),
              2'($urandom), 8'($urandom));
      end
    end

    // flipped screen and blanking
    SCREEN_FLIP = 1'b1;
    do_reset();
    idle();
    chk("flip_rst_hscrl", 32'(HPIXSCRL), 32'h1FF);
    chk("flip_rst_vscrl", 32'(VPIXSCRL), 32'hFF);
    run_to(3 * HT + 5); idle();
    chk("flip_hscrl", 32'(HPIXSCRL), 32'h1FA);
    chk("flip_vscrl", 32'(VPIXSCRL), 32'hFC);
    chk("flip_vpix", 32'(VPIX), 32'hFC);
    run_to(3 * HT + HA); idle();
    chk("hblank_256", 32'(HBLANK), 32'h1);
    run_to(VA * HT); idle();
    chk("vblank_va", 32'(VBLANK), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
